// File: rtl/multicycle_core.sv
// Multi-cycle RV32I/RV32E subset core with a single shared instruction/data
// memory port, ready-based wait states and a sticky illegal-instruction trap.
module multicycle_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Adr,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData,
    input  logic        MemReady,
    output logic [31:0] PC,
    output logic        Trap
);

    localparam int IDX_W = (REG_COUNT > 16) ? 5 : 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    state_t state, state_next, dec_next;

    logic [31:0] pc_q, old_pc, ir, a, b, imm, bta, alu_out, mdr;
    logic [31:0] rf [REG_COUNT];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_sel;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_res, rf_wdata;
    logic        rs1_ok, rs2_ok, rd_ok, alu_f3_ok, rf_we;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Only the register fields an instruction actually uses are range-checked.
    assign rs1_ok = ({27'd0, rs1} < 32'(REG_COUNT));
    assign rs2_ok = ({27'd0, rs2} < 32'(REG_COUNT));
    assign rd_ok  = ({27'd0, rd}  < 32'(REG_COUNT));

    assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                       (funct3 == 3'b110) || (funct3 == 3'b010);

    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1[IDX_W-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2[IDX_W-1:0]];

    always_comb begin
        dec_next = TRAP;
        imm_sel  = imm_i;
        case (opcode)
            OP_LOAD: begin
                if (funct3 == 3'b010 && rs1_ok && rd_ok) dec_next = MEMADR;
            end
            OP_STORE: begin
                imm_sel = imm_s;
                if (funct3 == 3'b010 && rs1_ok && rs2_ok) dec_next = MEMADR;
            end
            OP_REG: begin
                if (rs1_ok && rs2_ok && rd_ok &&
                    ((funct7 == 7'b0000000 && alu_f3_ok) ||
                     (funct7 == 7'b0100000 && funct3 == 3'b000)))
                    dec_next = EXECR;
            end
            OP_IMM: begin
                if (alu_f3_ok && rs1_ok && rd_ok) dec_next = EXECI;
            end
            OP_BRANCH: begin
                imm_sel = imm_b;
                if (funct3 == 3'b000 && rs1_ok && rs2_ok) dec_next = BEQ;
            end
            OP_JAL: begin
                imm_sel = imm_j;
                if (rd_ok) dec_next = JAL;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_b   = (state == EXECI) ? imm : b;
        alu_res = a + alu_b;
        case (funct3)
            3'b000: if (state == EXECR && funct7[5]) alu_res = a - alu_b;
            3'b111: alu_res = a & alu_b;
            3'b110: alu_res = a | alu_b;
            3'b010: alu_res = {31'd0, $signed(a) < $signed(alu_b)};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:    if (MemReady) state_next = DECODE;
            DECODE:   state_next = dec_next;
            MEMADR:   state_next = opcode[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (MemReady) state_next = MEMWB;
            MEMWRITE: if (MemReady) state_next = FETCH;
            EXECR,
            EXECI:    state_next = ALUWB;
            MEMWB,
            ALUWB,
            BEQ,
            JAL:      state_next = FETCH;
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    // Reset gates the request so nothing is issued while reset is held.
    always_comb begin
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        Adr       = pc_q;
        WriteData = '0;
        if (reset) begin
            case (state)
                FETCH: MemReq = 1'b1;
                MEMREAD: begin
                    Adr    = alu_out;
                    MemReq = 1'b1;
                end
                MEMWRITE: begin
                    Adr       = alu_out;
                    MemReq    = 1'b1;
                    MemWrite  = 1'b1;
                    WriteData = b;
                end
                default: ;
            endcase
        end
    end

    assign PC   = pc_q;
    assign Trap = (state == TRAP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            old_pc  <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            bta     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (MemReady) begin
                        ir     <= ReadData;
                        old_pc <= pc_q;
                        pc_q   <= pc_q + 32'd4;
                    end
                end
                DECODE: begin
                    a   <= rs1_val;
                    b   <= rs2_val;
                    imm <= imm_sel;
                    bta <= old_pc + imm_sel;
                    if (dec_next == TRAP) pc_q <= old_pc;
                end
                MEMADR:  alu_out <= a + imm;
                MEMREAD: if (MemReady) mdr <= ReadData;
                EXECR,
                EXECI:   alu_out <= alu_res;
                BEQ:     if (a == b) pc_q <= bta;
                JAL:     pc_q <= bta;
                default: ;
            endcase
        end
    end

    always_comb begin
        rf_wdata = alu_out;
        case (state)
            MEMWB:   rf_wdata = mdr;
            JAL:     rf_wdata = old_pc + 32'd4;
            default: ;
        endcase
        rf_we = ((state == MEMWB) || (state == ALUWB) || (state == JAL)) && (rd != 5'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else if (rf_we) begin
            rf[rd[IDX_W-1:0]] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Table-driven cycle-by-cycle bench for multicycle_core: three instances with
// different RESET_PC/REG_COUNT, each driven through hand-encoded programs.
module tb_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rstn  = 3'b000;
    logic        ready = 1'b0;
    logic [31:0] rdata = '0;

    logic [31:0] adr_a, wd_a, pc_a, adr_b, wd_b, pc_b, adr_c, wd_c, pc_c;
    logic        req_a, we_a, trap_a, req_b, we_b, trap_b, req_c, we_c, trap_c;

    multicycle_core #(.RESET_PC(32'h0000_0100), .REG_COUNT(32)) dut_a (
        .clk(clk), .reset(rstn[0]), .Adr(adr_a), .MemReq(req_a), .MemWrite(we_a),
        .WriteData(wd_a), .ReadData(rdata), .MemReady(ready), .PC(pc_a), .Trap(trap_a));

    multicycle_core #(.RESET_PC(32'h0000_0010), .REG_COUNT(32)) dut_b (
        .clk(clk), .reset(rstn[1]), .Adr(adr_b), .MemReq(req_b), .MemWrite(we_b),
        .WriteData(wd_b), .ReadData(rdata), .MemReady(ready), .PC(pc_b), .Trap(trap_b));

    multicycle_core #(.RESET_PC(32'h0000_0000), .REG_COUNT(16)) dut_c (
        .clk(clk), .reset(rstn[2]), .Adr(adr_c), .MemReq(req_c), .MemWrite(we_c),
        .WriteData(wd_c), .ReadData(rdata), .MemReady(ready), .PC(pc_c), .Trap(trap_c));

    typedef struct {
        logic [1:0]  inst;
        logic        rst;
        logic        rdy;
        logic [31:0] rdat;
        logic        req;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        trap;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic getOutputs(input logic [1:0] k, output logic req, output logic we,
                              output logic [31:0] adr, output logic [31:0] wd,
                              output logic [31:0] pc, output logic trap);
        case (k)
            2'd0:    begin req = req_a; we = we_a; adr = adr_a; wd = wd_a; pc = pc_a; trap = trap_a; end
            2'd1:    begin req = req_b; we = we_b; adr = adr_b; wd = wd_b; pc = pc_b; trap = trap_b; end
            default: begin req = req_c; we = we_c; adr = adr_c; wd = wd_c; pc = pc_c; trap = trap_c; end
        endcase
    endtask

    // One vector = one clock period; inputs change and outputs are sampled mid-cycle.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic        o_req, o_we, o_trap;
        logic [31:0] o_adr, o_wd, o_pc;
        @(negedge clk);
        rstn         = 3'b000;
        rstn[v.inst] = v.rst;
        ready        = v.rdy;
        rdata        = v.rdat;
        #1;
        getOutputs(v.inst, o_req, o_we, o_adr, o_wd, o_pc, o_trap);
        checkOutput($sformatf("v%0d.MemReq", idx), {31'd0, o_req}, {31'd0, v.req});
        checkOutput($sformatf("v%0d.MemWrite", idx), {31'd0, o_we}, {31'd0, v.we});
        checkOutput($sformatf("v%0d.PC", idx), o_pc, v.pc);
        checkOutput($sformatf("v%0d.Trap", idx), {31'd0, o_trap}, {31'd0, v.trap});
        if (v.req || !v.rst) checkOutput($sformatf("v%0d.Adr", idx), o_adr, v.adr);
        if (v.we || !v.rst)  checkOutput($sformatf("v%0d.WriteData", idx), o_wd, v.wd);
    endtask

    task automatic vReset(input logic [1:0] k, input logic [31:0] rpc);
        vecs.push_back('{k, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, rpc, 32'h0, rpc, 1'b0});
    endtask

    task automatic vFetch(input logic [1:0] k, input logic [31:0] p, input logic [31:0] instr, input logic r);
        vecs.push_back('{k, 1'b1, r, instr, 1'b1, 1'b0, p, 32'h0, p, 1'b0});
    endtask

    task automatic vIdle(input logic [1:0] k, input logic [31:0] p, input int n, input logic t);
        for (int i = 0; i < n; i++)
            vecs.push_back('{k, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, p, t});
    endtask

    task automatic vRead(input logic [1:0] k, input logic [31:0] ad, input logic [31:0] p,
                         input logic r, input logic [31:0] data);
        vecs.push_back('{k, 1'b1, r, data, 1'b1, 1'b0, ad, 32'h0, p, 1'b0});
    endtask

    task automatic vWrite(input logic [1:0] k, input logic [31:0] ad, input logic [31:0] d,
                          input logic [31:0] p, input logic r);
        vecs.push_back('{k, 1'b1, r, 32'h0, 1'b1, 1'b1, ad, d, p, 1'b0});
    endtask

    initial begin
        logic        o_req, o_we, o_trap;
        logic [31:0] o_adr, o_wd, o_pc;

        // Instance A (RESET_PC=0x100): addi/sw, lw with wait states, abort by reset.
        vReset(0, 32'h100);
        vFetch(0, 32'h100, 32'h00500193, 1);           // addi x3,x0,5
        vIdle(0, 32'h104, 3, 0);
        vFetch(0, 32'h104, 32'h0031A023, 1);           // sw x3,0(x3)
        vIdle(0, 32'h108, 2, 0);
        vWrite(0, 32'h5, 32'h5, 32'h108, 1);
        vFetch(0, 32'h108, 32'h0081A203, 1);           // lw x4,8(x3)
        vIdle(0, 32'h10C, 2, 0);
        vRead(0, 32'hD, 32'h10C, 0, 32'h12345678);
        vRead(0, 32'hD, 32'h10C, 0, 32'h12345678);
        vRead(0, 32'hD, 32'h10C, 0, 32'h12345678);
        vRead(0, 32'hD, 32'h10C, 1, 32'hDEADBEEF);
        vIdle(0, 32'h10C, 1, 0);
        vFetch(0, 32'h10C, 32'h00402023, 1);           // sw x4,0(x0)
        vIdle(0, 32'h110, 2, 0);
        vWrite(0, 32'h0, 32'hDEADBEEF, 32'h110, 0);
        vWrite(0, 32'h0, 32'hDEADBEEF, 32'h110, 1);
        vFetch(0, 32'h110, 32'h00402023, 1);
        vIdle(0, 32'h114, 2, 0);
        vWrite(0, 32'h0, 32'hDEADBEEF, 32'h114, 0);
        vReset(0, 32'h100);
        vFetch(0, 32'h100, 32'h00402023, 1);
        vIdle(0, 32'h104, 2, 0);
        vWrite(0, 32'h0, 32'h0, 32'h104, 1);
        vFetch(0, 32'h104, 32'h00000013, 0);

        // Instance B (RESET_PC=0x10): beq taken/not taken, jal, x0 immutability.
        vReset(1, 32'h10);
        vFetch(1, 32'h10, 32'hFE000EE3, 1);            // beq x0,x0,-4
        vIdle(1, 32'h14, 2, 0);
        vFetch(1, 32'h0C, 32'h00100093, 1);            // addi x1,x0,1
        vIdle(1, 32'h10, 3, 0);
        vFetch(1, 32'h10, 32'hFE008EE3, 1);            // beq x1,x0,-4
        vIdle(1, 32'h14, 2, 0);
        vFetch(1, 32'h14, 32'h00C0006F, 1);            // jal x0,+12
        vIdle(1, 32'h18, 2, 0);
        vFetch(1, 32'h20, 32'h0000007F, 0);
        vFetch(1, 32'h20, 32'h008000EF, 1);            // jal x1,+8
        vIdle(1, 32'h24, 2, 0);
        vFetch(1, 32'h28, 32'h00700013, 1);            // addi x0,x0,7
        vIdle(1, 32'h2C, 3, 0);
        vFetch(1, 32'h2C, 32'h00102023, 1);            // sw x1,0(x0)
        vIdle(1, 32'h30, 2, 0);
        vWrite(1, 32'h0, 32'h24, 32'h30, 1);
        vFetch(1, 32'h30, 32'h00002223, 1);            // sw x0,4(x0)
        vIdle(1, 32'h34, 2, 0);
        vWrite(1, 32'h4, 32'h0, 32'h34, 1);
        vFetch(1, 32'h34, 32'h00000013, 0);

        // Instance C (REG_COUNT=16): signed slt, sub, then traps.
        vReset(2, 32'h0);
        vFetch(2, 32'h00, 32'hFFD00293, 1);            // addi x5,x0,-3
        vIdle(2, 32'h04, 3, 0);
        vFetch(2, 32'h04, 32'h00200313, 1);            // addi x6,x0,2
        vIdle(2, 32'h08, 3, 0);
        vFetch(2, 32'h08, 32'h0062A3B3, 1);            // slt x7,x5,x6
        vIdle(2, 32'h0C, 3, 0);
        vFetch(2, 32'h0C, 32'h40530433, 1);            // sub x8,x6,x5
        vIdle(2, 32'h10, 3, 0);
        vFetch(2, 32'h10, 32'h00702023, 1);            // sw x7,0(x0)
        vIdle(2, 32'h14, 2, 0);
        vWrite(2, 32'h0, 32'h1, 32'h14, 1);
        vFetch(2, 32'h14, 32'h00802023, 1);            // sw x8,0(x0)
        vIdle(2, 32'h18, 2, 0);
        vWrite(2, 32'h0, 32'h5, 32'h18, 1);
        vFetch(2, 32'h18, 32'h00100893, 1);            // addi x17,x0,1
        vIdle(2, 32'h1C, 1, 0);
        vIdle(2, 32'h18, 3, 1);
        vReset(2, 32'h0);
        vFetch(2, 32'h00, 32'h0000007F, 1);
        vIdle(2, 32'h04, 1, 0);
        vIdle(2, 32'h00, 2, 1);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Reset asserted between clock edges while a load is waiting on memory.
        vecs.delete();
        vReset(0, 32'h100);
        vFetch(0, 32'h100, 32'h0081A203, 1);           // lw x4,8(x3), x3 cleared
        vIdle(0, 32'h104, 2, 0);
        vRead(0, 32'h8, 32'h104, 0, 32'hCAFEF00D);
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], 1000 + i);
        @(posedge clk);
        #3;
        rstn[0] = 1'b0;
        #1;
        getOutputs(2'd0, o_req, o_we, o_adr, o_wd, o_pc, o_trap);
        checkOutput("abort.MemReq", {31'd0, o_req}, 32'd0);
        checkOutput("abort.Adr", o_adr, 32'h100);
        checkOutput("abort.PC", o_pc, 32'h100);
        vecs.delete();
        vFetch(0, 32'h100, 32'h00000013, 0);
        applyStimulus(vecs[0], 2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
